sram_param: RTL and testbench
=============================

SRAM_PARAM -- requirements
Module: sram_param

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits; legal range 1..64.
REQ-002 Parameter ADDR_W, default 6: address width; memory depth DEPTH = 2**ADDR_W words.
REQ-003 Parameter INIT_VAL, default 0: DATA_W-bit value written to every word by the init sweep.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ramaddr  input  ADDR_W  word address for the current access.
REQ-007 ramin  input  DATA_W  write data.
REQ-008 rwbar  input  1  1 = read, 0 = write.
REQ-009 cs  input  1  chip select; an access is requested when cs=1.
REQ-010 clr  input  1  request to re-run the init sweep; sampled only in state READY.
REQ-011 flt_en  input  1  enables stuck-at fault injection on the read path.
REQ-012 flt_addr  input  ADDR_W  word address of the injected fault.
REQ-013 flt_bit  input  $clog2(DATA_W) (minimum 1)  bit index of the injected fault; values >= DATA_W inject no fault.
REQ-014 flt_val  input  1  stuck-at value of the faulty bit.
REQ-015 ramout  output  DATA_W  registered read data.
REQ-016 rd_valid  output  1  one-cycle pulse; ramout holds valid read data in that cycle.
REQ-017 busy  output  1  high while the init sweep runs; accesses are ignored while busy=1.

Function
REQ-018 The FSM SHALL have two states: INIT and READY.
REQ-019 In INIT, an ADDR_W-bit sweep counter SHALL write INIT_VAL to mem[cnt] each cycle and increment from 0 to DEPTH-1.
REQ-020 INIT -> READY on the edge that writes address DEPTH-1, so a sweep takes exactly DEPTH cycles; busy SHALL fall in the same edge.
REQ-021 READY -> INIT when clr=1; the counter SHALL restart at 0 and busy SHALL rise on that edge.
REQ-022 In READY with cs=1 and clr=0, a write (rwbar=0) SHALL store ramin at mem[ramaddr] on the edge.
REQ-023 In READY with cs=1 and clr=0, a read (rwbar=1) SHALL be accepted on edge N, with ramout = mem[ramaddr] and rd_valid=1 registered at edge N; read latency is 1 cycle.
REQ-024 When no read is accepted on an edge, ramout SHALL register 0 and rd_valid SHALL register 0.
REQ-025 clr=1 together with cs=1 in READY: clr wins; the access is dropped, with no write and no rd_valid.
REQ-026 cs=1 while busy=1 SHALL have no effect on memory, ramout or rd_valid.
REQ-027 Write to address A followed by a read of A on the next edge SHALL return the new data; there is no stale read.
REQ-028 Fault injection: on an accepted read where flt_en=1, ramaddr==flt_addr and flt_bit<DATA_W, registered ramout[flt_bit] SHALL equal flt_val; all other bits are unaffected.
REQ-029 Fault injection SHALL never modify stored memory contents; disabling flt_en restores the true data on the next read.
REQ-030 The counter SHALL not wrap into READY-state addressing; after DEPTH-1 it is don't-care until the next INIT entry.
REQ-031 Memory contents are undefined before the first sweep completes; no read can be accepted before then.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state=INIT, counter=0, busy=1, ramout=0 and rd_valid=0.
REQ-033 Memory contents SHALL not be reset directly; they are initialised by the sweep after rst_n deasserts.
REQ-034 rst_n asserted mid-sweep or mid-read SHALL abort the operation; the sweep restarts from address 0 with no rd_valid pulse.
REQ-035 Deassertion SHALL be synchronous to clk; the first sweep write occurs on the first rising edge with rst_n=1.

Verification
REQ-036 Release reset with defaults -> busy=1 for exactly 64 cycles, then a read of any address returns 0x00 with rd_valid=1 one cycle later.
REQ-037 Write 0xA5 to addr 10, then read addr 10 on the next cycle -> ramout=0xA5 with rd_valid=1; a read of addr 11 -> 0x00.
REQ-038 With 0xFF at addr 3, set flt_en=1, flt_addr=3, flt_bit=2, flt_val=0 and read addr 3 -> 0xFB; with flt_en=0, read again -> 0xFF.
REQ-039 Write 0x3C to addr 5, pulse clr with cs=1 and a write of 0x77 to addr 6 -> busy=1 for 64 cycles, then addr 5 and addr 6 both read 0x00.
REQ-040 Assert rst_n=0 at sweep count 20 -> busy stays 1, ramout=0, and the sweep restarts and takes 64 full cycles after release.
REQ-041 DATA_W=16, ADDR_W=4, INIT_VAL=0x1234: sweep takes 16 cycles, every address reads 0x1234, and a write/read of 0xBEEF at addr 15 round-trips.

Source files
------------

// File: rtl/sram_param.sv
// Parameterised single-port SRAM with a power-up/clear init sweep, one-cycle
// registered read path and optional stuck-at fault injection on read data.
module sram_param #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 6,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0,
  localparam int                FB_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ramaddr,
  input  logic [DATA_W-1:0] ramin,
  input  logic              rwbar,
  input  logic              cs,
  input  logic              clr,
  input  logic              flt_en,
  input  logic [ADDR_W-1:0] flt_addr,
  input  logic [FB_W-1:0]   flt_bit,
  input  logic              flt_val,
  output logic [DATA_W-1:0] ramout,
  output logic              rd_valid,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] ramout_q, ramout_d;
  logic              rd_valid_q, rd_valid_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              rd_acc;
  logic [DATA_W-1:0] rd_data;
  logic              flt_hit;

  // Sweep owns the write port in INIT; user accesses only count in READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    mem_wa  = ramaddr;
    mem_wd  = ramin;
    rd_acc  = 1'b0;
    case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = INIT_VAL;
        cnt_d  = cnt_q + ADDR_W'(1);
        if (&cnt_q) begin
          state_d = ST_READY;
        end
      end
      default: begin
        if (clr) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else if (cs) begin
          if (rwbar) begin
            rd_acc = 1'b1;
          end else begin
            mem_we = 1'b1;
          end
        end
      end
    endcase
  end

  // Fault only corrupts the value leaving the array, never the stored word.
  always_comb begin
    rd_data = mem[ramaddr];
    flt_hit = flt_en && (ramaddr == flt_addr);
    for (int b = 0; b < DATA_W; b++) begin
      if (flt_hit && (FB_W'(b) == flt_bit)) begin
        rd_data[b] = flt_val;
      end
    end
  end

  always_comb begin
    ramout_d   = rd_acc ? rd_data : '0;
    rd_valid_d = rd_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      ramout_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ramout_q   <= ramout_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Array has no reset; contents come only from the sweep or user writes.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign ramout   = ramout_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == ST_INIT);

endmodule

// File: tb/tb_sram_param.sv
// Self-checking bench for sram_param: a default 8x64 instance and a 16x16
// instance with a non-zero init value, read data checked through scoreboards.
module tb_sram_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: defaults (DATA_W=8, ADDR_W=6, INIT_VAL=0)
  logic [5:0]  a_ramaddr, a_flt_addr;
  logic [7:0]  a_ramin, a_ramout;
  logic [2:0]  a_flt_bit;
  logic        a_rwbar, a_cs, a_clr, a_flt_en, a_flt_val, a_rd_valid, a_busy;

  // Instance B: DATA_W=16, ADDR_W=4, INIT_VAL=0x1234
  logic [3:0]  b_ramaddr, b_flt_addr, b_flt_bit;
  logic [15:0] b_ramin, b_ramout;
  logic        b_rwbar, b_cs, b_clr, b_flt_en, b_flt_val, b_rd_valid, b_busy;

  sram_param u_a (
    .clk(clk), .rst_n(rst_n), .ramaddr(a_ramaddr), .ramin(a_ramin),
    .rwbar(a_rwbar), .cs(a_cs), .clr(a_clr), .flt_en(a_flt_en),
    .flt_addr(a_flt_addr), .flt_bit(a_flt_bit), .flt_val(a_flt_val),
    .ramout(a_ramout), .rd_valid(a_rd_valid), .busy(a_busy)
  );

  sram_param #(.DATA_W(16), .ADDR_W(4), .INIT_VAL(16'h1234)) u_b (
    .clk(clk), .rst_n(rst_n), .ramaddr(b_ramaddr), .ramin(b_ramin),
    .rwbar(b_rwbar), .cs(b_cs), .clr(b_clr), .flt_en(b_flt_en),
    .flt_addr(b_flt_addr), .flt_bit(b_flt_bit), .flt_val(b_flt_val),
    .ramout(b_ramout), .rd_valid(b_rd_valid), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [7:0]  a_q[$];
  logic [15:0] b_q[$];

  // Scoreboard monitors: every rd_valid pops one expected word; idle cycles
  // must show ramout == 0.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (a_rd_valid) begin
        if (a_q.size() == 0) begin
          errors++;
          $display("FAIL a_spurious_rd_valid: ramout=%h, no read pending", a_ramout);
        end else begin
          logic [7:0] e;
          e = a_q.pop_front();
          if (a_ramout !== e) begin
            errors++;
            $display("FAIL a_read_data: got %h expected %h", a_ramout, e);
          end else begin
            $display("a read ok: data=%h", a_ramout);
          end
        end
      end else if (a_ramout !== 8'h00) begin
        errors++;
        $display("FAIL a_idle_ramout: got %h expected 00", a_ramout);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (b_rd_valid) begin
        if (b_q.size() == 0) begin
          errors++;
          $display("FAIL b_spurious_rd_valid: ramout=%h, no read pending", b_ramout);
        end else begin
          logic [15:0] e;
          e = b_q.pop_front();
          if (b_ramout !== e) begin
            errors++;
            $display("FAIL b_read_data: got %h expected %h", b_ramout, e);
          end else begin
            $display("b read ok: data=%h", b_ramout);
          end
        end
      end else if (b_ramout !== 16'h0000) begin
        errors++;
        $display("FAIL b_idle_ramout: got %h expected 0000", b_ramout);
      end
    end
  end

  task automatic a_wr(input logic [5:0] addr, input logic [7:0] d);
    a_ramaddr = addr; a_ramin = d; a_rwbar = 1'b0; a_cs = 1'b1;
    $display("a write addr=%0d data=%h", addr, d);
    @(negedge clk);
  endtask

  task automatic a_rd(input logic [5:0] addr, input logic [7:0] e);
    a_ramaddr = addr; a_rwbar = 1'b1; a_cs = 1'b1;
    a_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic b_wr(input logic [3:0] addr, input logic [15:0] d);
    b_ramaddr = addr; b_ramin = d; b_rwbar = 1'b0; b_cs = 1'b1;
    $display("b write addr=%0d data=%h", addr, d);
    @(negedge clk);
  endtask

  task automatic b_rd(input logic [3:0] addr, input logic [15:0] e);
    b_ramaddr = addr; b_rwbar = 1'b1; b_cs = 1'b1;
    b_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    a_cs = 1'b0; b_cs = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Count edges with busy still high; caller is at a negedge with busy=1.
  task automatic count_a_busy(output int n);
    n = 0;
    while (a_busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_cs = 0; a_clr = 0; a_rwbar = 1; a_ramaddr = 0; a_ramin = 0;
    a_flt_en = 0; a_flt_addr = 0; a_flt_bit = 0; a_flt_val = 0;
    b_cs = 0; b_clr = 0; b_rwbar = 1; b_ramaddr = 0; b_ramin = 0;
    b_flt_en = 0; b_flt_addr = 0; b_flt_bit = 0; b_flt_val = 0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    checks++;
    if (a_busy !== 1'b1 || a_rd_valid !== 1'b0 || a_ramout !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: busy=%b rd_valid=%b ramout=%h expected 1 0 00",
               a_busy, a_rd_valid, a_ramout);
    end
    $display("reset state busy=%b rd_valid=%b ramout=%h", a_busy, a_rd_valid, a_ramout);
  endtask

  task automatic test_first_sweep;
    int n;
    rst_n = 1'b1;
    count_a_busy(n);
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL first_sweep_len: busy cycles=%0d expected 64", n);
    end
    $display("first sweep busy cycles=%0d", n);
    a_rd(0, 8'h00); a_rd(31, 8'h00); a_rd(63, 8'h00);
    idle(2);
  endtask

  task automatic test_write_read;
    a_wr(10, 8'hA5); a_rd(10, 8'hA5); a_rd(11, 8'h00);
    idle(2);
  endtask

  task automatic test_back_to_back;
    a_wr(20, 8'h11); a_wr(21, 8'h22); a_rd(20, 8'h11); a_rd(21, 8'h22);
    a_wr(20, 8'h33); a_rd(20, 8'h33); a_rd(21, 8'h22);
    idle(2);
  endtask

  task automatic test_fault;
    a_wr(3, 8'hFF);
    a_flt_en = 1'b1; a_flt_addr = 3; a_flt_bit = 2; a_flt_val = 1'b0;
    a_rd(3, 8'hFB);
    a_rd(10, 8'hA5);
    a_flt_bit = 7; a_flt_val = 1'b1; a_flt_addr = 10;
    a_rd(10, 8'hA5);
    a_flt_addr = 11;
    a_rd(11, 8'h80);
    a_flt_en = 1'b0;
    a_rd(3, 8'hFF);
    a_rd(11, 8'h00);
    idle(2);
  endtask

  task automatic test_clr;
    int n;
    a_wr(5, 8'h3C);
    a_wr(0, 8'h5A);
    a_ramaddr = 6; a_ramin = 8'h77; a_rwbar = 1'b0; a_cs = 1'b1; a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    checks++;
    if (a_busy !== 1'b1) begin
      errors++;
      $display("FAIL clr_busy_rise: busy=%b expected 1", a_busy);
    end
    // Hammer the port while busy; none of it may land.
    n = 0;
    while (a_busy === 1'b1 && n < 200) begin
      a_cs = 1'b1;
      a_rwbar = (n == 60) ? 1'b0 : 1'b1;
      a_ramaddr = (n == 60) ? 6'd0 : 6'd9;
      a_ramin = 8'h99;
      @(negedge clk);
      n++;
    end
    a_cs = 1'b0;
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL clr_sweep_len: busy cycles=%0d expected 64", n);
    end
    $display("clr sweep busy cycles=%0d", n);
    a_rd(5, 8'h00); a_rd(6, 8'h00); a_rd(0, 8'h00); a_rd(10, 8'h00);
    idle(2);
  endtask

  task automatic test_reset_mid_sweep;
    int n;
    a_cs = 1'b1; a_rwbar = 1'b1; a_clr = 1'b1; a_ramaddr = 1;
    @(negedge clk);
    a_clr = 1'b0; a_cs = 1'b0;
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_busy !== 1'b1 || a_ramout !== 8'h00 || a_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_sweep_reset: busy=%b ramout=%h rd_valid=%b expected 1 00 0",
               a_busy, a_ramout, a_rd_valid);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    count_a_busy(n);
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL mid_sweep_restart_len: busy cycles=%0d expected 64", n);
    end
    $display("restart sweep busy cycles=%0d", n);
    a_rd(63, 8'h00);
    idle(2);
  endtask

  task automatic test_small_config;
    int n;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (b_busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL b_sweep_len: busy cycles=%0d expected 16", n);
    end
    $display("b sweep busy cycles=%0d", n);
    for (int i = 0; i < 16; i++) begin
      b_rd(4'(i), 16'h1234);
    end
    b_wr(15, 16'hBEEF); b_rd(15, 16'hBEEF); b_rd(14, 16'h1234);
    b_flt_en = 1'b1; b_flt_addr = 15; b_flt_bit = 4'd0; b_flt_val = 1'b0;
    b_rd(15, 16'hBEEE);
    b_flt_en = 1'b0;
    b_rd(15, 16'hBEEF);
    idle(3);
  endtask

  initial begin
    test_reset();
    test_first_sweep();
    test_write_read();
    test_back_to_back();
    test_fault();
    test_clr();
    test_reset_mid_sweep();
    test_small_config();
    checks++;
    if (a_q.size() != 0 || b_q.size() != 0) begin
      errors++;
      $display("FAIL pending_reads: a=%0d b=%0d outstanding expected 0 0",
               a_q.size(), b_q.size());
    end
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
